// File: rtl/rst_pkg.sv
// Shared types and constants for the reset sequencer slice.
// The sequencer FSM state encoding lives here so the bench and RTL agree on it.
package rst_pkg;

   typedef enum logic [2:0] {ASSERT, RELEASE, RUN, SOFT, SOFT_SEQ} rst_state_e;

   localparam int RST_MIN_SYNC_STAGES = 2;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rst_sync_n.sv
// Asynchronous-set / synchronous-release reset synchroniser chain.
// sync_rst asserts immediately with reset and deasserts SYNC_STAGES clk edges after it falls.
module rst_sync_n
   import rst_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   output logic sync_rst
);

   // Clamp so a mis-set parameter can never produce a chain shorter than two flops.
   localparam int STAGES = max_int(SYNC_STAGES, RST_MIN_SYNC_STAGES);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chain <= '1;
      end else begin
         chain <= {chain[STAGES-2:0], 1'b0};
      end
   end

   assign sync_rst = chain[STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset synchroniser and sequencer: releases rst_out bits in ascending order, GAP_CYCLES apart,
// with a four-phase soft-reset replay. Define RST_SEQ_REVERSE_ASSERT_EN for staggered soft assertion.
module rst_seq_ctrl
   import rst_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int N_OUT       = 4,
   parameter int GAP_CYCLES  = 8,
   parameter int HOLD_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             soft_req,
   output logic             soft_ack,
   output logic [N_OUT-1:0] rst_out,
   output logic             all_released
);

   localparam int CNT_W = $clog2(max_int(GAP_CYCLES, HOLD_CYCLES) + 1);
   localparam int IDX_W = $clog2(N_OUT + 1);

   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_OUT - 1);

   rst_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic             soft_pending;
   logic             sync_rst;

   rst_sync_n #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .reset    (reset),
      .sync_rst (sync_rst)
   );

`ifdef RST_SEQ_REVERSE_ASSERT_EN
   localparam logic [N_OUT-1:0] TOP_BIT = N_OUT'(1) << (N_OUT - 1);
`endif

   // soft_pending stays set from soft entry until soft_req is seen low in RUN,
   // which both blocks a second replay and drives soft_ack.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ASSERT;
         cnt          <= '0;
         idx          <= '0;
         rst_out      <= '1;
         all_released <= 1'b0;
         soft_ack     <= 1'b0;
         soft_pending <= 1'b0;
      end else begin
         case (state)
            ASSERT: begin
               if (!sync_rst) begin
                  state <= RELEASE;
                  cnt   <= '0;
                  idx   <= '0;
               end
            end

            RELEASE: begin
               if (cnt == GAP_LAST) begin
                  rst_out <= rst_out & ~(N_OUT'(1) << idx);
                  cnt     <= '0;
                  idx     <= idx + IDX_W'(1);
                  if (idx == IDX_LAST) begin
                     state        <= RUN;
                     all_released <= 1'b1;
                     soft_ack     <= soft_pending;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            RUN: begin
               if (soft_req && !soft_pending) begin
                  soft_pending <= 1'b1;
                  soft_ack     <= 1'b0;
                  all_released <= 1'b0;
                  cnt          <= '0;
`ifdef RST_SEQ_REVERSE_ASSERT_EN
                  if (N_OUT == 1) begin
                     state   <= SOFT;
                     rst_out <= '1;
                  end else begin
                     state   <= SOFT_SEQ;
                     rst_out <= TOP_BIT;
                     idx     <= IDX_W'(N_OUT - 2);
                  end
`else
                  state   <= SOFT;
                  rst_out <= '1;
`endif
               end else if (!soft_req) begin
                  soft_pending <= 1'b0;
                  soft_ack     <= 1'b0;
               end else begin
                  soft_ack <= soft_pending;
               end
            end

`ifdef RST_SEQ_REVERSE_ASSERT_EN
            // Walk downwards asserting one bit per gap; bit 0 hands over to the hold phase.
            SOFT_SEQ: begin
               if (cnt == GAP_LAST) begin
                  rst_out <= rst_out | (N_OUT'(1) << idx);
                  cnt     <= '0;
                  if (idx == '0) begin
                     state <= SOFT;
                  end else begin
                     idx <= idx - IDX_W'(1);
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
`endif

            SOFT: begin
               if (cnt == HOLD_LAST) begin
                  state <= RELEASE;
                  cnt   <= '0;
                  idx   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            default: begin
               state        <= ASSERT;
               cnt          <= '0;
               idx          <= '0;
               rst_out      <= '1;
               all_released <= 1'b0;
               soft_ack     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: expected per-edge outputs are queued from timeline formulas.
// Honours RST_SEQ_REVERSE_ASSERT_EN for the soft-reset expectations.
module tb_rst_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset, reset_b;
   logic       soft_req, soft_req_b;
   logic [3:0] rst_out;
   logic       all_released, soft_ack;
   logic [0:0] rst_out_b;
   logic       all_released_b, soft_ack_b;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic [3:0] rst;
      logic       rel;
      logic       ack;
   } exp_t;

   exp_t exp_q[$];

`ifdef RST_SEQ_REVERSE_ASSERT_EN
   localparam int SOFT_REL0 = 1 + 8 * 3 + 4 + 8;
`else
   localparam int SOFT_REL0 = 1 + 4 + 8;
`endif

   always #5 clk = ~clk;

   rst_seq_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .soft_req     (soft_req),
      .soft_ack     (soft_ack),
      .rst_out      (rst_out),
      .all_released (all_released)
   );

   rst_seq_ctrl #(
      .SYNC_STAGES (3),
      .N_OUT       (1),
      .GAP_CYCLES  (1)
   ) dut_b (
      .clk          (clk),
      .reset        (reset_b),
      .soft_req     (soft_req_b),
      .soft_ack     (soft_ack_b),
      .rst_out      (rst_out_b),
      .all_released (all_released_b)
   );

   // Edge k counts clk edges after reset falls; bit i releases at edge 11 + 8*i.
   function automatic exp_t exp_boot(input int k);
      exp_t e;
      int   r;
      r = 0;
      for (int i = 0; i < 4; i++) if (k >= 11 + 8 * i) r++;
      e.rst = 4'hF << r;
      e.rel = (r == 4);
      e.ack = 1'b0;
      return e;
   endfunction

   // Edge s counts from the soft entry edge (s = 1).
   function automatic exp_t exp_soft(input int s, input logic held);
      exp_t e;
      int   at;
      e.rst = 4'h0;
      for (int b = 0; b < 4; b++) begin
`ifdef RST_SEQ_REVERSE_ASSERT_EN
         at = 1 + 8 * (3 - b);
`else
         at = 1;
`endif
         e.rst[b] = (s >= at) && (s < SOFT_REL0 + 8 * b);
      end
      e.rel = (s >= SOFT_REL0 + 24);
      e.ack = e.rel && held;
      return e;
   endfunction

   task automatic test_reset();
      reset = 1'b0; reset_b = 1'b0; soft_req = 1'b0; soft_req_b = 1'b0;
      #1 reset = 1'b1; reset_b = 1'b1;
      #1;
      n_cmp++;
      if (rst_out !== 4'hF) begin n_err++; $display("[TB] FAIL reset_rst_out got %h want f", rst_out); end
      n_cmp++;
      if (all_released !== 1'b0) begin n_err++; $display("[TB] FAIL reset_all_rel got %b want 0", all_released); end
      n_cmp++;
      if (soft_ack !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ack got %b want 0", soft_ack); end
      n_cmp++;
      if (rst_out_b !== 1'b1) begin n_err++; $display("[TB] FAIL reset_b_rst_out got %b want 1", rst_out_b); end
      repeat (3) @(posedge clk);
   endtask

   task automatic test_boot(input string name);
      exp_t e;
      @(negedge clk) reset = 1'b0;
      for (int k = 1; k <= 40; k++) exp_q.push_back(exp_boot(k));
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         n_cmp++;
         if (rst_out !== e.rst) begin n_err++; $display("[TB] FAIL %s_rst_out edge %0d got %h want %h", name, k, rst_out, e.rst); end
         n_cmp++;
         if (all_released !== e.rel) begin n_err++; $display("[TB] FAIL %s_all_rel edge %0d got %b want %b", name, k, all_released, e.rel); end
         n_cmp++;
         if (soft_ack !== e.ack) begin n_err++; $display("[TB] FAIL %s_ack edge %0d got %b want %b", name, k, soft_ack, e.ack); end
      end
   endtask

   task automatic test_mid_reset();
      exp_t e;
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      for (int k = 1; k <= 20; k++) exp_q.push_back(exp_boot(k));
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         n_cmp++;
         if (rst_out !== e.rst) begin n_err++; $display("[TB] FAIL mid_rst_out edge %0d got %h want %h", k, rst_out, e.rst); end
      end
      #3 reset = 1'b1;
      #1;
      n_cmp++;
      if (rst_out !== 4'hF) begin n_err++; $display("[TB] FAIL mid_async_rst_out got %h want f", rst_out); end
      n_cmp++;
      if (all_released !== 1'b0) begin n_err++; $display("[TB] FAIL mid_async_all_rel got %b want 0", all_released); end
      test_boot("mid_replay");
   endtask

   task automatic test_soft();
      exp_t e;
      int   n;
      n = SOFT_REL0 + 28;
      @(negedge clk) soft_req = 1'b1;
      for (int s = 1; s <= n; s++) exp_q.push_back(exp_soft(s, 1'b1));
      for (int s = 1; s <= n; s++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         n_cmp++;
         if (rst_out !== e.rst) begin n_err++; $display("[TB] FAIL soft_rst_out edge %0d got %h want %h", s, rst_out, e.rst); end
         n_cmp++;
         if (all_released !== e.rel) begin n_err++; $display("[TB] FAIL soft_all_rel edge %0d got %b want %b", s, all_released, e.rel); end
         n_cmp++;
         if (soft_ack !== e.ack) begin n_err++; $display("[TB] FAIL soft_ack edge %0d got %b want %b", s, soft_ack, e.ack); end
      end
      @(negedge clk) soft_req = 1'b0;
      for (int s = 1; s <= 12; s++) begin
         @(posedge clk); #1;
         n_cmp++;
         if ({rst_out, all_released, soft_ack} !== 6'b0000_1_0) begin
            n_err++;
            $display("[TB] FAIL soft_drop edge %0d got %h/%b/%b want 0/1/0", s, rst_out, all_released, soft_ack);
         end
      end
   endtask

   task automatic test_soft_during_release();
      exp_t e;
      int   n;
      n = 35 + SOFT_REL0 + 28;
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      for (int k = 1; k <= n; k++)
         exp_q.push_back((k <= 35) ? exp_boot(k) : exp_soft(k - 35, 1'b1));
      for (int k = 1; k <= n; k++) begin
         if (k == 15) @(negedge clk) soft_req = 1'b1;
         @(posedge clk); #1;
         e = exp_q.pop_front();
         n_cmp++;
         if (rst_out !== e.rst) begin n_err++; $display("[TB] FAIL early_soft_rst_out edge %0d got %h want %h", k, rst_out, e.rst); end
         n_cmp++;
         if (all_released !== e.rel) begin n_err++; $display("[TB] FAIL early_soft_all_rel edge %0d got %b want %b", k, all_released, e.rel); end
         n_cmp++;
         if (soft_ack !== e.ack) begin n_err++; $display("[TB] FAIL early_soft_ack edge %0d got %b want %b", k, soft_ack, e.ack); end
      end
      @(negedge clk) soft_req = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (soft_ack !== 1'b0) begin n_err++; $display("[TB] FAIL early_soft_ack_drop got %b want 0", soft_ack); end
   endtask

   task automatic test_short_pulse();
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      n_cmp++;
      if (rst_out !== 4'hF) begin n_err++; $display("[TB] FAIL pulse_rst_out got %h want f", rst_out); end
      #2 reset = 1'b0;
      // Pulse ends before the next rising edge; test_boot waits for the negedge after it.
      // Re-arm the window so the first edge after the pulse is edge 1.
      reset = 1'b1;
      #0 reset = 1'b0;
      test_boot_after_pulse();
   endtask

   task automatic test_boot_after_pulse();
      exp_t e;
      for (int k = 1; k <= 40; k++) exp_q.push_back(exp_boot(k));
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         n_cmp++;
         if (rst_out !== e.rst) begin n_err++; $display("[TB] FAIL pulse_rst_out edge %0d got %h want %h", k, rst_out, e.rst); end
         n_cmp++;
         if (all_released !== e.rel) begin n_err++; $display("[TB] FAIL pulse_all_rel edge %0d got %b want %b", k, all_released, e.rel); end
      end
   endtask

   task automatic test_small_config();
      @(negedge clk) reset_b = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (rst_out_b !== ((k < 5) ? 1'b1 : 1'b0)) begin
            n_err++; $display("[TB] FAIL small_rst_out edge %0d got %b want %b", k, rst_out_b, (k < 5));
         end
         n_cmp++;
         if (all_released_b !== ((k >= 5) ? 1'b1 : 1'b0)) begin
            n_err++; $display("[TB] FAIL small_all_rel edge %0d got %b want %b", k, all_released_b, (k >= 5));
         end
      end
   endtask

   initial begin
      test_reset();
      test_boot("boot");
      test_mid_reset();
      test_soft();
      test_soft_during_release();
      test_short_pulse();
      test_small_config();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
